// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free 4-digit common-anode scan with dead-time and leading-zero blanking
module seg7_scan_driver #(
    parameter int DIV  = 50000,
    parameter int DEAD = 4
) (
    input  logic        gclk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_start
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic          run;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   d_sh, d_nx;
    logic [3:0]    p_sh, p_nx;
    logic          lz_sh, lz_nx;
    logic          snap, b3, b2, b1, drive;
    logic [3:0]    blank, cur;
    logic [6:0]    code;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    endfunction

    // next scan position, frame snapshot and the pattern the coming cycle should show
    always_comb begin
        snap  = !run || (cnt == LAST && idx == 2'd3);
        cnt_n = (!run || cnt == LAST) ? '0 : cnt + 1'b1;
        idx_n = !run ? 2'd0 : (cnt == LAST ? idx + 2'd1 : idx);
        d_nx  = snap ? digits : d_sh;
        p_nx  = snap ? dp : p_sh;
        lz_nx = snap ? lz_en : lz_sh;
        b3    = lz_nx && d_nx[15:12] == 4'd0 && !p_nx[3];
        b2    = b3 && d_nx[11:8] == 4'd0 && !p_nx[2];
        b1    = b2 && d_nx[7:4] == 4'd0 && !p_nx[1];
        blank = {b3, b2, b1, 1'b0};
        cur   = d_nx[{idx_n, 2'b00} +: 4];
        code  = dec(cur);
        drive = cnt_n >= DEAD_C && !blank[idx_n];
    end

    // state and registered outputs; the first edge after reset starts frame 0
    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            cnt         <= '0;
            idx         <= 2'd0;
            d_sh        <= '0;
            p_sh        <= '0;
            lz_sh       <= 1'b0;
            an          <= 4'hf;
            seg         <= 7'h7f;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            cnt         <= cnt_n;
            idx         <= idx_n;
            d_sh        <= d_nx;
            p_sh        <= p_nx;
            lz_sh       <= lz_nx;
            an          <= drive ? ~(4'b0001 << idx_n) : 4'hf;
            seg         <= drive ? code : 7'h7f;
            dp_n        <= drive ? ~p_nx[idx_n] : 1'b1;
            frame_start <= snap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed table, corner sequences and random run against a frame-level model
module tb_seg7_scan_driver;
    localparam int DIV = 8;
    localparam int DEAD = 2;
    localparam int FR = 4 * DIV;

    logic        gclk = 0, reset = 0, lz_en = 0;
    logic [15:0] digits = 0;
    logic [3:0]  dp = 0;
    logic [6:0]  seg;
    logic        dp_n, frame_start;
    logic [3:0]  an;

    int checks = 0, errors = 0;
    logic [6:0]  tab [16];
    logic [15:0] sd;
    logic [3:0]  sp;
    logic        sl;

    typedef struct {
        logic [15:0]      d;
        logic [3:0]       p;
        logic             lz;
        logic [3:0]       lit;
        logic [3:0][6:0]  segs;
        logic [3:0]       dpn;
    } vec_t;
    vec_t vecs [5];

    seg7_scan_driver #(.DIV(DIV), .DEAD(DEAD)) dut (
        .gclk(gclk), .reset(reset), .digits(digits), .dp(dp), .lz_en(lz_en),
        .seg(seg), .dp_n(dp_n), .an(an), .frame_start(frame_start)
    );

    always #5 gclk = ~gclk;

    task automatic cmp(input string nm, input int t, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef);
        checks++;
        if ({an, seg, dp_n, frame_start} !== {ea, es, ed, ef}) begin
            errors++;
            $display("FAIL %s t=%0d an=%b/%b seg=%b/%b dp_n=%b/%b fs=%b/%b (got/want)",
                     nm, t, an, ea, seg, es, dp_n, ed, frame_start, ef);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        cmp("reset", -1, 4'hf, 7'h7f, 1'b1, 1'b0);
        @(negedge gclk);
        reset = 1;
    endtask

    // frame-level reference: which digit is showing and whether leading zeros hide it
    task automatic mcheck(input string nm, input int t);
        int s, ph;
        logic lead;
        logic [3:0] bl, ea;
        logic [6:0] es;
        logic ed;
        if (t % FR == 0) begin
            sd = digits; sp = dp; sl = lz_en;
        end
        s = (t % FR) / DIV;
        ph = t % DIV;
        lead = sl;
        bl = 4'b0;
        for (int k = 3; k >= 1; k--) begin
            lead = lead && sd[k*4 +: 4] == 4'd0 && !sp[k];
            bl[k] = lead;
        end
        ea = 4'hf; es = 7'h7f; ed = 1'b1;
        if (ph >= DEAD && !bl[s]) begin
            ea = 4'hf & ~(4'b0001 << s);
            es = tab[sd[s*4 +: 4]];
            ed = ~sp[s];
        end
        cmp(nm, t, ea, es, ed, t % FR == 0);
    endtask

    initial begin
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        int s, ph;
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011,
                    {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'h0012, 4'b0100, 1'b1, 4'b0111,
                    {7'b1111111, 7'b1000000, 7'b1111001, 7'b0100100}, 4'b1011};
        vecs[4] = '{16'h00AF, 4'b0000, 1'b0, 4'b1111,
                    {7'b1000000, 7'b1000000, 7'b0111111, 7'b0111111}, 4'b1111};

        for (int i = 0; i < 5; i++) begin
            digits = vecs[i].d; dp = vecs[i].p; lz_en = vecs[i].lz;
            do_reset();
            for (int t = 0; t <= 2 * FR; t++) begin
                tick();
                s = (t % FR) / DIV;
                ph = t % DIV;
                ea = 4'hf; es = 7'h7f; ed = 1'b1;
                if (ph >= DEAD && vecs[i].lit[s]) begin
                    ea = 4'hf & ~(4'b0001 << s);
                    es = vecs[i].segs[s];
                    ed = vecs[i].dpn[s];
                end
                cmp($sformatf("table%0d", i), t, ea, es, ed, t % FR == 0);
            end
        end

        digits = 16'h1234; dp = 0; lz_en = 0;
        do_reset();
        for (int t = 0; t < 2 * FR; t++) begin
            tick();
            mcheck("snapshot", t);
            if (t == 12) cmp("snap_old", t, 4'b1101, 7'b0110000, 1'b1, 1'b0);
            if (t == 34) cmp("snap_new0", t, 4'b1110, 7'b0000000, 1'b1, 1'b0);
            if (t == 44) cmp("snap_new1", t, 4'b1101, 7'b1111000, 1'b1, 1'b0);
            if (t == 11) digits = 16'h5678;
        end

        digits = 16'h1234;
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            tick();
            mcheck("pre_reset", t);
        end
        cmp("slot2_drive", 20, 4'b1011, 7'b0100100, 1'b1, 1'b0);
        reset = 0;
        #1;
        cmp("reset_async", 20, 4'hf, 7'h7f, 1'b1, 1'b0);
        digits = 16'h9876;
        tick();
        cmp("reset_hold", 20, 4'hf, 7'h7f, 1'b1, 1'b0);
        @(negedge gclk);
        reset = 1;
        for (int t = 0; t <= FR; t++) begin
            tick();
            mcheck("post_reset", t);
            if (t == 0) cmp("restart", t, 4'hf, 7'h7f, 1'b1, 1'b1);
            if (t == 2) cmp("fresh_snap", t, 4'b1110, 7'b0000010, 1'b1, 1'b0);
        end

        for (int r = 0; r < 4; r++) begin
            digits = 16'($urandom); dp = 4'($urandom); lz_en = 1'($urandom);
            do_reset();
            for (int t = 0; t < 10 * FR; t++) begin
                tick();
                mcheck("random", t);
                if ($urandom_range(0, 5) == 0) begin
                    digits = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom) & 16'h00ff;
                    dp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
                    lz_en = 1'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes four BCD digits from the cascaded decade-counter chain and drives the panel's shared segment lines and per-digit anode enables. It sits directly downstream of the counters and upstream of the board pins. It snapshots all four digits once per frame so the display never tears, inserts a dead-time gap at every digit switch to suppress ghosting, and optionally blanks leading zeros.

## Interface
- DIV, 50000: clock cycles per digit slot; DIV ≥ 2.
- DEAD, 4: blank cycles at the start of each slot; 1 ≤ DEAD < DIV.
- gclk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- digits  in  16  BCD inputs: digit3=[15:12] (leftmost) … digit0=[3:0] (rightmost).
- dp  in  4  decimal-point request per digit, bit i = digit i, active-high.
- lz_en  in  1  leading-zero blanking enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal-point segment, active-low.
- an  out  4  anode enables, bit i = digit i, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- Prescaler cnt runs 0..DIV-1. When cnt = DIV-1, cnt returns to 0 and slot index idx advances 0→1→2→3→0.
- Slot order is rightmost first: idx 0 = digit0.
- Each slot has two phases:
  - DEAD, cnt < DEAD: an=4'b1111, seg=7'b1111111, dp_n=1.
  - DRIVE, cnt ≥ DEAD: an has only bit idx low, seg/dp_n show the snapshot digit.
- Snapshot: digits, dp and lz_en are sampled into shadow registers on the cycle slot 0 begins (idx wraps to 0, cnt=0). Input changes at any other time take effect at the next frame only.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes A–F show a dash: 0111111.
- dp_n = ~dp_shadow[idx] during DRIVE.
- Leading-zero blanking (only when shadow lz_en=1):
  - digit3 is blanked if it equals 0 and its dp bit is 0.
  - digit2 is blanked if it equals 0, its dp bit is 0, and digit3 is blanked.
  - digit1 follows the same rule relative to digit2.
  - digit0 is never blanked.
- A blanked slot keeps an=1111, seg=1111111 and dp_n=1 for its whole duration; slot timing is unchanged.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, immediate): cnt=0, idx=0, all shadows 0, an=4'b1111, seg=7'b1111111, dp_n=1, frame_start=0.
- Output cycle 0 is the first rising edge after reset release. It is cycle 0 of slot 0 (DEAD phase, frame_start=1), with the snapshot taken at that edge.
- Slot k occupies output cycles k·DIV .. k·DIV+DIV-1, relative to the frame start. The anode is low during cycles k·DIV+DEAD .. k·DIV+DIV-1.
- Frame period is 4·DIV cycles. frame_start is high for exactly one cycle per frame.
- seg and an change on the same edge. No cycle ever has two anode bits low.
- An anode drops low no earlier than DEAD cycles after the previous anode rose.
- Reset asserted mid-slot: outputs are forced dark immediately. After release, the sequence restarts at slot 0, DEAD phase, with a new snapshot.
- Input glitches or changes mid-frame have no visible effect until the next frame_start.

## Test plan
All scenarios use DIV=8, DEAD=2, and cycles counted from the first edge after reset release.
- **Basic scan:** digits=16'h1234, dp=0, lz_en=0.
  - Required: cycles 0–1 an=1111; cycles 2–7 an=1110, seg=0011001.
  - Cycles 10–15 an=1101, seg=0110000. Cycles 18–23 an=1011, seg=0100100. Cycles 26–31 an=0111, seg=1111001.
  - frame_start=1 at cycles 0, 32, 64.
- **Leading-zero blanking:** digits=16'h0050, lz_en=1.
  - Required: slot 0 shows 1000000, slot 1 shows 0010010.
  - Slots 2 and 3 keep an=1111 for all 16 cycles.
  - Variant: digits=16'h0000 lights only slot 0 with 1000000.
- **Decimal point stops blanking:** digits=16'h0012, dp=4'b0100, lz_en=1.
  - Required: slot 2 shows 1000000 with dp_n=0; slot 3 is blanked; dp_n=1 in all other slots.
- **Snapshot isolation:** digits=16'h1234, changed to 16'h5678 at cycle 12 (inside slot 1).
  - Required: slots 1–3 of frame 0 still show 3, 2, 1.
  - Frame 1 (cycles 32–63) shows 8, 7, 6, 5.
- **Invalid BCD:** digits=16'h00AF, lz_en=0.
  - Required: slots 0 and 1 show seg=0111111; slots 2 and 3 show 1000000.
- **Reset mid-operation:** assert reset at cycle 20 (slot 2 DRIVE).
  - Required: an=1111, seg=1111111 and dp_n=1 before the next clock edge, held while reset is low.
  - After release: a new cycle 0 with frame_start=1, DEAD phase, and a fresh snapshot.
